// File: rtl/store_stage_if.sv
// Execute->store packet bus: execute drives the packet, store answers with in_ready.
interface store_stage_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 64,
  parameter int REG_ID_W  = 5
);
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  in_kind;
  logic [NUM_LANES-1:0]        in_exec_mask;
  logic [DATA_W-1:0]           in_pc;
  logic [REG_ID_W-1:0]         in_reg_id;
  logic [NUM_LANES*DATA_W-1:0] in_vec_a;
  logic [NUM_LANES*DATA_W-1:0] in_vec_b;
  logic [DATA_W-1:0]           in_tgt0;
  logic [DATA_W-1:0]           in_tgt1;
  logic [NUM_LANES-1:0]        in_mask0;
  logic [NUM_LANES-1:0]        in_mask1;
  logic                        in_restore_pc;

  modport master (
    output in_valid, in_kind, in_exec_mask, in_pc, in_reg_id, in_vec_a, in_vec_b,
           in_tgt0, in_tgt1, in_mask0, in_mask1, in_restore_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_exec_mask, in_pc, in_reg_id, in_vec_a, in_vec_b,
           in_tgt0, in_tgt1, in_mask0, in_mask1, in_restore_pc,
    output in_ready
  );
endinterface

// File: rtl/store_stage.sv
// Store stage: retires execute packets (writeback, per-lane memory ops, fetch redirects, halt).
// Latency: 1 cycle WB / 1 per redirect / 1 per store lane / 2 per load lane; one packet in flight.
// Backpressure: in_ready only in IDLE; requests held until ready. STORE_STAGE_STATS_EN adds counters.
module store_stage #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 64,
  parameter int REG_ID_W  = 5,
  parameter int REG_PC_ID = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  store_stage_if.slave                ex,
  output logic                        rf_we,
  output logic [REG_ID_W-1:0]         rf_wr_id,
  output logic [NUM_LANES*DATA_W-1:0] rf_wr_data,
  output logic [NUM_LANES-1:0]        rf_wr_mask,
  output logic                        rf_mark_valid,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [DATA_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_W-1:0]           mem_rsp_data,
  output logic                        redir_valid,
  input  logic                        redir_ready,
  output logic [DATA_W-1:0]           redir_pc,
  output logic [NUM_LANES-1:0]        redir_mask,
  output logic                        halted
`ifdef STORE_STAGE_STATS_EN
  ,
  output logic [31:0]                 stat_retired,
  output logic [31:0]                 stat_mem_ops,
  output logic [31:0]                 stat_stall_cycles
`endif
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [2:0] K_HALT = 3'd0, K_JMP = 3'd1, K_CJMP = 3'd2;
  localparam logic [2:0] K_LOAD = 3'd3, K_STORE = 3'd4, K_STVAL = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_MEM_REQ, S_MEM_RSP, S_WB, S_REDIR0, S_REDIR1, S_HALT} state_t;
  state_t state, state_nxt;

  logic [2:0]                  kind_q;
  logic [NUM_LANES-1:0]        mask_q, mask0_q, mask1_q;
  logic [REG_ID_W-1:0]         reg_id_q;
  logic [NUM_LANES*DATA_W-1:0] vec_a_q, vec_b_q;
  logic [DATA_W-1:0]           tgt0_q, tgt1_q;
  logic                        restore_q;
  logic [LW-1:0]               lane_q, lane_first_q;
  logic [DATA_W-1:0]           lane_buf [NUM_LANES];

  logic          accept;
  logic [LW-1:0] in_first, lane_nxt;
  logic          in_any, lane_more;

  assign ex.in_ready = (state == S_IDLE);
  assign accept      = ex.in_valid && ex.in_ready;

  // Descending scan so the lowest qualifying lane wins.
  always_comb begin
    in_first  = '0;
    in_any    = 1'b0;
    lane_nxt  = '0;
    lane_more = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (ex.in_exec_mask[i]) begin
        in_first = i[LW-1:0];
        in_any   = 1'b1;
      end
      if (mask_q[i] && (i > int'(lane_q))) begin
        lane_nxt  = i[LW-1:0];
        lane_more = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (ex.in_kind)
            K_HALT:  state_nxt = S_HALT;
            K_JMP:   state_nxt = (ex.in_exec_mask != '0) ? S_REDIR0 : S_IDLE;
            K_CJMP: begin
              if (ex.in_mask0 != '0)      state_nxt = S_REDIR0;
              else if (ex.in_mask1 != '0) state_nxt = S_REDIR1;
              else                        state_nxt = S_IDLE;
            end
            K_LOAD, K_STORE: state_nxt = in_any ? S_MEM_REQ : S_WB;
            K_STVAL: state_nxt = S_WB;
            default: state_nxt = S_IDLE;  // unknown kinds are dropped
          endcase
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          if (kind_q == K_LOAD) state_nxt = S_MEM_RSP;
          else if (!lane_more)  state_nxt = S_IDLE;
        end
      end
      S_MEM_RSP: if (mem_rsp_valid) state_nxt = lane_more ? S_MEM_REQ : S_WB;
      S_WB:      state_nxt = (kind_q == K_LOAD && restore_q && mask_q != '0) ? S_REDIR0 : S_IDLE;
      S_REDIR0:  if (redir_ready) state_nxt = (kind_q == K_CJMP && mask1_q != '0) ? S_REDIR1 : S_IDLE;
      S_REDIR1:  if (redir_ready) state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      kind_q       <= '0;
      mask_q       <= '0;
      mask0_q      <= '0;
      mask1_q      <= '0;
      reg_id_q     <= '0;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      tgt0_q       <= '0;
      tgt1_q       <= '0;
      restore_q    <= 1'b0;
      lane_q       <= '0;
      lane_first_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) lane_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        kind_q       <= ex.in_kind;
        mask_q       <= ex.in_exec_mask;
        mask0_q      <= ex.in_mask0;
        mask1_q      <= ex.in_mask1;
        reg_id_q     <= ex.in_reg_id;
        vec_a_q      <= ex.in_vec_a;
        vec_b_q      <= ex.in_vec_b;
        tgt0_q       <= ex.in_tgt0;
        tgt1_q       <= ex.in_tgt1;
        restore_q    <= ex.in_restore_pc;
        lane_q       <= in_first;
        lane_first_q <= in_first;
      end
      if (state == S_MEM_REQ && mem_req_ready && kind_q != K_LOAD && lane_more)
        lane_q <= lane_nxt;
      if (state == S_MEM_RSP && mem_rsp_valid) begin
        lane_buf[lane_q] <= mem_rsp_data;
        if (lane_more) lane_q <= lane_nxt;
      end
    end
  end

  always_comb begin
    rf_we         = (state == S_WB);
    rf_mark_valid = rf_we;
    rf_wr_id      = '0;
    rf_wr_mask    = '0;
    rf_wr_data    = '0;
    if (rf_we) begin
      rf_wr_id   = (kind_q == K_LOAD && restore_q) ? REG_ID_W'(REG_PC_ID) : reg_id_q;
      rf_wr_mask = mask_q;
      for (int i = 0; i < NUM_LANES; i++)
        if (mask_q[i])
          rf_wr_data[i*DATA_W +: DATA_W] = (kind_q == K_LOAD) ? lane_buf[i] : vec_a_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    mem_req_valid = (state == S_MEM_REQ);
    mem_req_we    = mem_req_valid && (kind_q == K_STORE);
    mem_req_addr  = mem_req_valid ? vec_a_q[int'(lane_q)*DATA_W +: DATA_W] : '0;
    mem_req_wdata = mem_req_we ? vec_b_q[int'(lane_q)*DATA_W +: DATA_W] : '0;
    redir_valid   = (state == S_REDIR0) || (state == S_REDIR1);
    redir_pc      = '0;
    redir_mask    = '0;
    if (state == S_REDIR0) begin
      redir_pc   = (kind_q == K_LOAD) ? lane_buf[lane_first_q] : tgt0_q;
      redir_mask = (kind_q == K_CJMP) ? mask0_q : mask_q;
    end else if (state == S_REDIR1) begin
      redir_pc   = tgt1_q;
      redir_mask = mask1_q;
    end
    halted = (state == S_HALT);
  end

`ifdef STORE_STAGE_STATS_EN
  logic retire_evt;
  assign retire_evt = (state_nxt == S_IDLE) &&
                      ((state != S_IDLE) || (accept && ex.in_kind <= K_STVAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_retired      <= '0;
      stat_mem_ops      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (retire_evt) stat_retired <= stat_retired + 32'd1;
      if (mem_req_valid && mem_req_ready) stat_mem_ops <= stat_mem_ops + 32'd1;
      if ((mem_req_valid && !mem_req_ready) || (redir_valid && !redir_ready))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif
endmodule
